// File: rtl/frame_buffer_arbiter.sv
// rtl/frame_buffer_arbiter.sv - SRAM frame-buffer arbiter: display reads over queued dot-draw writes
// Optional full-screen clear sweep is built only when FB_CLEAR_EN is defined.
module frame_buffer_arbiter #(
    parameter int H_RES         = 640,
    parameter int V_RES         = 480,
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 18,
    parameter int FIFO_DEPTH    = 8,
    parameter int WR_BLANK_ONLY = 1
) (
    input  logic                          SRAMClk,
    input  logic                          Reset,
    input  logic                          VGA_BLANK_N,
    input  logic                          rd_req,
    input  logic [9:0]                    rd_x,
    input  logic [9:0]                    rd_y,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [9:0]                    wr_x,
    input  logic [9:0]                    wr_y,
    input  logic [DATA_W-1:0]             wr_color,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    input  logic                          clear,
    input  logic [DATA_W-1:0]             clear_color,
    output logic                          clear_busy,
    output logic [ADDR_W-1:0]             SRAM_ADDR,
    output logic [DATA_W-1:0]             SRAM_DQ_O,
    input  logic [DATA_W-1:0]             SRAM_DQ_I,
    output logic                          SRAM_WE_N,
    output logic                          SRAM_OE_N
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [10:0]       H_LIM = 11'(H_RES);
    localparam logic [10:0]       V_LIM = 11'(V_RES);
    localparam logic [ADDR_W-1:0] H_MUL = ADDR_W'(H_RES);

    typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_t;
    state_t state;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [9:0] y);
        return ADDR_W'(y) * H_MUL + ADDR_W'(x);
    endfunction

    function automatic logic off_screen(input logic [9:0] x, input logic [9:0] y);
        return ({1'b0, x} >= H_LIM) || ({1'b0, y} >= V_LIM);
    endfunction

    logic [9:0]        fifo_x [FIFO_DEPTH];
    logic [9:0]        fifo_y [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_c [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              full, push, pop;
    logic [9:0]        head_x, head_y;
    logic [DATA_W-1:0] head_c;
    logic              head_oor;

    logic              rd_pend, rd_pend_oor, rd_take, rd_oor_q;
    logic [ADDR_W-1:0] rd_pend_addr;

    logic              blank_ok, clr_go, clr_issue;
    logic [ADDR_W-1:0] clr_addr;

    assign full       = count == LVL_W'(FIFO_DEPTH);
    assign push       = wr_valid && !full;
    assign wr_ready   = !full;
    assign fifo_level = count;
    assign head_x     = fifo_x[rd_ptr];
    assign head_y     = fifo_y[rd_ptr];
    assign head_c     = fifo_c[rd_ptr];
    assign head_oor   = off_screen(head_x, head_y);

    // A pending read always wins the next bus slot, so writes only start from an idle bus with none waiting.
    assign blank_ok  = (WR_BLANK_ONLY == 0) || !VGA_BLANK_N;
    assign clr_issue = (state == IDLE) && !rd_pend && clr_go;
    assign pop       = (state == IDLE) && !rd_pend && !clear_busy && blank_ok && (count != '0);
    assign rd_take   = rd_pend && ((state == IDLE) || (state == TURN) || ((state == WRITE) && rd_pend_oor));

    always_ff @(posedge SRAMClk) begin
        if (push) begin
            fifo_x[wr_ptr] <= wr_x;
            fifo_y[wr_ptr] <= wr_y;
            fifo_c[wr_ptr] <= wr_color;
        end
    end

    always_ff @(posedge SRAMClk) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // One-deep read holding slot; a request arriving while it is still occupied is dropped.
    always_ff @(posedge SRAMClk) begin
        if (Reset) begin
            rd_pend      <= 1'b0;
            rd_pend_oor  <= 1'b0;
            rd_pend_addr <= '0;
        end else if (rd_req && (!rd_pend || rd_take)) begin
            rd_pend      <= 1'b1;
            rd_pend_oor  <= off_screen(rd_x, rd_y);
            rd_pend_addr <= pix_addr(rd_x, rd_y);
        end else if (rd_take) begin
            rd_pend <= 1'b0;
        end
    end

    always_ff @(posedge SRAMClk) begin
        if (Reset) begin
            state     <= IDLE;
            SRAM_ADDR <= '0;
            SRAM_DQ_O <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_oor_q  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_pend) begin
                        rd_oor_q  <= rd_pend_oor;
                        SRAM_OE_N <= rd_pend_oor;
                        if (!rd_pend_oor) SRAM_ADDR <= rd_pend_addr;
                        state <= READ;
                    end else if (clr_issue) begin
                        SRAM_ADDR <= clr_addr;
                        SRAM_DQ_O <= clear_color;
                        SRAM_WE_N <= 1'b0;
                        state     <= WRITE;
                    end else if (pop && !head_oor) begin
                        SRAM_ADDR <= pix_addr(head_x, head_y);
                        SRAM_DQ_O <= head_c;
                        SRAM_WE_N <= 1'b0;
                        state     <= WRITE;
                    end
                end
                READ: begin
                    SRAM_OE_N <= 1'b1;
                    rd_valid  <= 1'b1;
                    rd_data   <= rd_oor_q ? '0 : SRAM_DQ_I;
                    state     <= IDLE;
                end
                WRITE: begin
                    // Off-screen reads need no bus, so they skip the turnaround cycle.
                    SRAM_WE_N <= 1'b1;
                    if (rd_pend && rd_pend_oor) begin
                        rd_oor_q <= 1'b1;
                        state    <= READ;
                    end else if (rd_pend) begin
                        state <= TURN;
                    end else begin
                        state <= IDLE;
                    end
                end
                TURN: begin
                    rd_oor_q  <= 1'b0;
                    SRAM_ADDR <= rd_pend_addr;
                    SRAM_OE_N <= 1'b0;
                    state     <= READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    logic              clear_q, clr_last;
    logic [ADDR_W-1:0] clr_cnt;

    assign clr_go   = clear_busy && blank_ok;
    assign clr_addr = clr_cnt;

    // A rising clear restarts the sweep even mid-sweep; that assignment is last so it wins.
    always_ff @(posedge SRAMClk) begin
        if (Reset) begin
            clear_q    <= 1'b0;
            clear_busy <= 1'b0;
            clr_last   <= 1'b0;
            clr_cnt    <= '0;
        end else begin
            clear_q <= clear;
            if (clr_issue) begin
                clr_cnt  <= clr_cnt + 1'b1;
                clr_last <= clr_cnt == LAST_ADDR;
            end
            if (state == WRITE && clr_last) begin
                clear_busy <= 1'b0;
                clr_last   <= 1'b0;
            end
            if (clear && !clear_q) begin
                clear_busy <= 1'b1;
                clr_last   <= 1'b0;
                clr_cnt    <= '0;
            end
        end
    end
`else
    logic unused_clear;
    assign unused_clear = clear;
    assign clr_go       = 1'b0;
    assign clr_addr     = '0;
    assign clear_busy   = 1'b0;
`endif
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb/tb_frame_buffer_arbiter.sv - directed self-checking bench for frame_buffer_arbiter
module tb_frame_buffer_arbiter;
    logic        SRAMClk = 1'b0;
    always #5 SRAMClk = ~SRAMClk;

    logic        Reset, VGA_BLANK_N, rd_req, wr_valid, clear;
    logic [9:0]  rd_x, rd_y, wr_x, wr_y;
    logic [15:0] wr_color, clear_color, SRAM_DQ_I;
    logic [15:0] rd_data, SRAM_DQ_O;
    logic        rd_valid, wr_ready, clear_busy, SRAM_WE_N, SRAM_OE_N;
    logic [3:0]  fifo_level;
    logic [17:0] SRAM_ADDR;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [33:0] wq[$];

    frame_buffer_arbiter dut (
        .SRAMClk(SRAMClk), .Reset(Reset), .VGA_BLANK_N(VGA_BLANK_N),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .fifo_level(fifo_level), .clear(clear), .clear_color(clear_color), .clear_busy(clear_busy),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_I(SRAM_DQ_I),
        .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N)
    );

    always @(negedge SRAMClk) if (!Reset && !SRAM_WE_N) wq.push_back({SRAM_ADDR, SRAM_DQ_O});

`ifdef FB_CLEAR_EN
    logic [15:0] c_rd_data, c_dq_o;
    logic        c_rd_valid, c_wr_ready, c_busy, c_we_n, c_oe_n;
    logic [3:0]  c_level;
    logic [17:0] c_addr;
    logic [33:0] cq[$];

    frame_buffer_arbiter #(.H_RES(4), .V_RES(2), .WR_BLANK_ONLY(0)) dut_c (
        .SRAMClk(SRAMClk), .Reset(Reset), .VGA_BLANK_N(VGA_BLANK_N),
        .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_data(c_rd_data), .rd_valid(c_rd_valid),
        .wr_valid(wr_valid), .wr_ready(c_wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
        .fifo_level(c_level), .clear(clear), .clear_color(clear_color), .clear_busy(c_busy),
        .SRAM_ADDR(c_addr), .SRAM_DQ_O(c_dq_o), .SRAM_DQ_I(SRAM_DQ_I),
        .SRAM_WE_N(c_we_n), .SRAM_OE_N(c_oe_n)
    );

    always @(negedge SRAMClk) if (!Reset && !c_we_n) cq.push_back({c_addr, c_dq_o});
`endif

    task automatic tick(input int n = 1);
        repeat (n) @(posedge SRAMClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_draw(input logic [9:0] x, input logic [9:0] y, input logic [15:0] c);
        wr_x = x; wr_y = y; wr_color = c; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; VGA_BLANK_N = 1'b1; rd_req = 1'b0; rd_x = '0; rd_y = '0;
        wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
        clear = 1'b0; clear_color = '0; SRAM_DQ_I = '0;
        tick(3);
        chk("rst_we_n", SRAM_WE_N, 1);
        chk("rst_oe_n", SRAM_OE_N, 1);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rst_dq_o", SRAM_DQ_O, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_clear_busy", clear_busy, 0);
        Reset = 1'b0;
        tick();

        // plain read at (0,0): OE one cycle, data two edges after the request edge
        SRAM_DQ_I = 16'hABCD; rd_x = 10'd0; rd_y = 10'd0; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("rd0_oe_idle", SRAM_OE_N, 1);
        tick();
        chk("rd0_oe_low", SRAM_OE_N, 0);
        chk("rd0_addr", SRAM_ADDR, 0);
        chk("rd0_valid_early", rd_valid, 0);
        tick();
        chk("rd0_valid", rd_valid, 1);
        chk("rd0_data", rd_data, 16'hABCD);
        chk("rd0_oe_high", SRAM_OE_N, 1);
        tick();
        chk("rd0_valid_pulse", rd_valid, 0);

        // draws held while not blanking, then drained in order
        for (int i = 0; i < 8; i++) push_draw(10'(5 + i), 10'd2, 16'h1000 + 16'(i));
        chk("fill_level", fifo_level, 8);
        chk("fill_wr_ready", wr_ready, 0);
        push_draw(10'd100, 10'd2, 16'hDEAD);
        chk("full_refuse_level", fifo_level, 8);
        chk("fill_no_we", wq.size(), 0);
        VGA_BLANK_N = 1'b0;
        tick(20);
        chk("drain_level", fifo_level, 0);
        chk("drain_wr_ready", wr_ready, 1);
        chk("drain_count", wq.size(), 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("drain_w%0d", i), (i < wq.size()) ? wq[i] : 34'h0,
                {18'(1285 + i), 16'h1000 + 16'(i)});

        // read requested as a write issues: turnaround, 3-cycle latency
        wq.delete();
        SRAM_DQ_I = 16'h5A5A;
        push_draw(10'd1, 10'd0, 16'h0022);
        rd_x = 10'd3; rd_y = 10'd1; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("turn_we_low", SRAM_WE_N, 0);
        chk("turn_w_addr", SRAM_ADDR, 1);
        tick();
        chk("turn_we_high", SRAM_WE_N, 1);
        chk("turn_oe_high", SRAM_OE_N, 1);
        tick();
        chk("turn_oe_low", SRAM_OE_N, 0);
        chk("turn_r_addr", SRAM_ADDR, 643);
        chk("turn_valid_early", rd_valid, 0);
        tick();
        chk("turn_valid", rd_valid, 1);
        chk("turn_data", rd_data, 16'h5A5A);
        chk("turn_wcount", wq.size(), 1);
        chk("turn_wfirst", (wq.size() > 0) ? wq[0] : 34'h0, {18'd1, 16'h0022});

        // off-screen draw and read
        wq.delete();
        push_draw(10'd640, 10'd0, 16'h0033);
        tick(4);
        chk("oor_draw_level", fifo_level, 0);
        chk("oor_draw_no_we", wq.size(), 0);
        SRAM_DQ_I = 16'hFFFF; rd_x = 10'd0; rd_y = 10'd480; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        chk("oor_rd_no_oe", SRAM_OE_N, 1);
        chk("oor_rd_valid_early", rd_valid, 0);
        tick();
        chk("oor_rd_valid", rd_valid, 1);
        chk("oor_rd_data", rd_data, 0);

        // reset in the middle of a write with queued draws
        VGA_BLANK_N = 1'b1;
        for (int i = 0; i < 4; i++) push_draw(10'(20 + i), 10'd3, 16'h0050 + 16'(i));
        chk("mid_level4", fifo_level, 4);
        VGA_BLANK_N = 1'b0;
        tick();
        chk("mid_we_low", SRAM_WE_N, 0);
        chk("mid_level3", fifo_level, 3);
        Reset = 1'b1;
        tick();
        wq.delete();
        chk("mid_rst_we", SRAM_WE_N, 1);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_ready", wr_ready, 1);
        Reset = 1'b0;
        tick(4);
        chk("mid_rst_no_writes", wq.size(), 0);

`ifdef FB_CLEAR_EN
        cq.delete();
        clear_color = 16'h7FFF; VGA_BLANK_N = 1'b1;
        wr_x = 10'd1; wr_y = 10'd1; wr_color = 16'h0044; wr_valid = 1'b1; clear = 1'b1;
        tick();
        wr_valid = 1'b0; clear = 1'b0;
        chk("clr_busy_rise", c_busy, 1);
        tick(10);
        chk("clr_busy_mid", c_busy, 1);
        tick(20);
        chk("clr_busy_fall", c_busy, 0);
        chk("clr_count", cq.size(), 9);
        for (int i = 0; i < 8; i++)
            chk($sformatf("clr_w%0d", i), (i < cq.size()) ? cq[i] : 34'h0, {18'(i), 16'h7FFF});
        chk("clr_draw_after", (cq.size() > 8) ? cq[8] : 34'h0, {18'd5, 16'h0044});
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
